mac_pe_os_ws: RTL

- Parametrised fixed-point MAC processing element for the systolic array; successor to the single-mode PE.
- Supports output-stationary (OS) and weight-stationary (WS) dataflow selected at run time.
- In OS mode, an FSM accumulates a programmed number of products, then holds the result behind a valid/ready handshake.
- Adds signed saturation with a sticky overflow flag. Instantiated per array cell; result handshake feeds the column drain and recompute logic.

---
 rtl/mac_pe_os_ws.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mac_pe_os_ws.sv
// Fixed-point MAC processing element, output- or weight-stationary at run time.
// Optional `FAULT_INJECT_EN adds fault_inject_in to force the product word.
module mac_pe_os_ws #(
    parameter int WORD_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int CNT_W     = 8,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FAULT_INJECT_EN
    input  logic [1:0]           fault_inject_in,
`endif
    input  logic                 mode_in,
    input  logic                 load_stat_in,
    input  logic                 start_in,
    input  logic [CNT_W-1:0]     k_len_in,
    input  logic                 valid_in,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic                 valid_out,
    output logic [WORD_SIZE-1:0] result_out,
    output logic                 result_valid_out,
    input  logic                 result_ready_in,
    output logic                 busy_out,
    output logic                 overflow_out
);

    localparam int PW  = 2 * WORD_SIZE;
    localparam int PTW = PW - FRAC_BITS;
    localparam int HW  = PTW - WORD_SIZE + 1;

    localparam logic [WORD_SIZE-1:0] MAX_W = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] MIN_W = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WORD_SIZE-1:0] left_q, top_q, stat_q;
    logic                 valid_q;
    logic                 mode_q, mode_d;
    logic [WORD_SIZE-1:0] acc_q, acc_d;
    logic [WORD_SIZE-1:0] psum_q, psum_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [WORD_SIZE-1:0] op2;
    logic signed [PW-1:0] prod_full;
    logic [PTW-1:0]       prod_top;
    logic [HW-1:0]        prod_hi;
    logic                 prod_ovf;
    logic [WORD_SIZE-1:0] prod_w;
    logic [WORD_SIZE-1:0] add_a;
    logic [WORD_SIZE:0]   sum_w;
    logic                 add_ovf;
    logic [WORD_SIZE-1:0] add_res;
    logic                 step_ovf;

    assign op2       = mode_q ? stat_q : top_q;
    assign prod_full = $signed(left_q) * $signed(op2);
    assign prod_top  = PTW'(prod_full >>> FRAC_BITS);
    assign prod_hi   = prod_top[PTW-1:WORD_SIZE-1];

    // Product slice with optional clamp; injection overrides the word entirely.
    always_comb begin
        prod_ovf = !((&prod_hi) || (~|prod_hi));
        if ((SATURATE != 0) && prod_ovf)
            prod_w = prod_top[PTW-1] ? MIN_W : MAX_W;
        else
            prod_w = prod_top[WORD_SIZE-1:0];
`ifdef FAULT_INJECT_EN
        if (fault_inject_in[0]) begin
            prod_w   = {WORD_SIZE{fault_inject_in[1]}};
            prod_ovf = 1'b0;
        end
`endif
    end

    // Shared saturating adder: north partial sum in WS, accumulator in OS.
    always_comb begin
        add_a   = mode_q ? top_q : acc_q;
        sum_w   = {add_a[WORD_SIZE-1], add_a} + {prod_w[WORD_SIZE-1], prod_w};
        add_ovf = sum_w[WORD_SIZE] != sum_w[WORD_SIZE-1];
        if ((SATURATE != 0) && add_ovf)
            add_res = sum_w[WORD_SIZE] ? MIN_W : MAX_W;
        else
            add_res = sum_w[WORD_SIZE-1:0];
        step_ovf = add_ovf | prod_ovf;
    end

    // Next-state for the OS sequencer and the WS partial-sum path.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        psum_d  = psum_q;
        mode_d  = (state_q == IDLE) ? mode_in : mode_q;

        if (mode_q && valid_q) begin
            psum_d = add_res;
            ovf_d  = ovf_q | step_ovf;
        end

        unique case (state_q)
            IDLE: begin
                if (start_in && !mode_in) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = k_len_in;
                    state_d = (k_len_in == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (valid_q) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | step_ovf;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (result_ready_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers: input skew stage, stationary operand, results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_q  <= '0;
            top_q   <= '0;
            valid_q <= 1'b0;
            stat_q  <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            left_q  <= left_in;
            top_q   <= top_in;
            valid_q <= valid_in;
            if (load_stat_in)
                stat_q <= top_in;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign right_out        = left_q;
    assign valid_out        = valid_q;
    assign bottom_out       = mode_q ? psum_q : top_q;
    assign result_out       = acc_q;
    assign result_valid_out = (state_q == HOLD);
    assign busy_out         = (state_q != IDLE);
    assign overflow_out     = ovf_q;

endmodule
